uart_tx_fifo: RTL and testbench

//  Transmit-only 8N1 UART with an internal byte FIFO, used by the SPI-to-UART debug bridge.
//  The upstream logic pushes bytes with a single-cycle strobe whenever fifo_ready is high.
//  The block serialises queued bytes back-to-back onto the TX pin at BAUD_RATE.

---
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-only 8N1 UART with a byte queue in front of it. The upstream
//   logic pushes bytes with start_uart while fifo_ready is high, and queued
//   bytes go out back-to-back on tx. Consecutive frames are separated by
//   exactly one idle clock.
//
// Parameters
//   CLOCK_FREQUENCY  system clock in Hz
//   BAUD_RATE        line rate in bit/s; BAUD_DIV = CLOCK_FREQUENCY/BAUD_RATE
//   FIFO_DEPTH       queue entries (power of two, >= 2)
//
// Configuration
//   UART_TX_FIFO_EN  defined   : FIFO_DEPTH-entry circular FIFO
//                    undefined : single holding register (FIFO_DEPTH ignored)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active high
//   start_uart  in   enqueue strobe, level sampled every clock
//   data        in   byte to enqueue, valid with start_uart
//   tx          out  registered serial output, idle high
//   fifo_ready  out  high when an enqueue would be accepted
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_uart,
  input  logic [7:0] data,
  output logic       tx,
  output logic       fifo_ready
);

  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             baud_last;
  logic             have_data;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // The FSM takes the head byte only from IDLE; this is the single pop point.
  assign pop       = (state == S_IDLE) && have_data;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Full test uses the registered count, so a push coinciding with the pop
  // that frees a slot is still dropped.
  assign fifo_ready = (count != FULL_CNT);
  assign push       = start_uart && fifo_ready;
  assign have_data  = (count != '0);
  assign head       = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count, and leaving the
  // array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_valid;

  assign fifo_ready = !hold_valid;
  assign push       = start_uart && !hold_valid;
  assign have_data  = hold_valid;
  assign head       = hold_q;

  // push needs an empty holder and pop a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_q     <= data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Transmit FSM. shift is loaded only at pop and shifted right as each data
  // bit is launched, refilling with ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= head;
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            shift    <= {1'b1, shift[7:1]};
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              shift   <= {1'b1, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo at default parameters (BAUD_DIV=234).
//   A behavioural model (byte queue + frame-position counter) is advanced on
//   every rising edge from the same inputs the DUT sees. Each test compares
//   tx and fifo_ready with it on the falling edge, and adds direct checks of
//   the expected values at key points.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int B = 27000000 / 115200;  // 234 clocks per bit
  localparam int FRAME = 10 * B;
`ifdef UART_TX_FIFO_EN
  localparam int M_DEPTH = 64;
`else
  localparam int M_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_uart = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       fifo_ready;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] mq[$];
  bit         m_busy = 1'b0;
  int         m_e = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_tx = 1'b1;
  logic       m_rdy;

  uart_tx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .start_uart (start_uart),
    .data       (data),
    .tx         (tx),
    .fifo_ready (fifo_ready)
  );

  always #5 clk = ~clk;

  // line level at bit position idx of an 8N1 frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // One clock: advance the model on the rising edge, return on the falling edge.
  task automatic tick();
    int old_size;
    bit do_pop;
    bit do_push;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_e    = 0;
      m_tx   = 1'b1;
    end else begin
      old_size = mq.size();
      do_pop   = !m_busy && (old_size != 0);
      do_push  = start_uart && (old_size != M_DEPTH);
      if (m_busy) begin
        m_e++;
        if (m_e == FRAME) begin
          m_busy = 1'b0;
          m_tx   = 1'b1;
        end else begin
          m_tx = frame_bit(m_cur, m_e / B);
        end
      end else if (do_pop) begin
        m_cur  = mq.pop_front();
        m_busy = 1'b1;
        m_e    = 0;
        m_tx   = 1'b0;
      end
      if (do_push) mq.push_back(data);
    end
    m_rdy = (mq.size() != M_DEPTH);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_uart = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tx !== 1'b1) begin
        bad++;
        $display("FAIL reset_tx cyc=%0d got=%b exp=1", i, tx);
      end
      total++;
      if (fifo_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, fifo_ready);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic exp;
    do_reset();
    start_uart = 1'b1;
    data = 8'h55;
    tick();
    start_uart = 1'b0;
    for (int j = 0; j < FRAME + 3; j++) begin
      tick();
      if (j < B) exp = 1'b0;
      else if (j >= 9 * B) exp = 1'b1;
      else exp = 1'((8'h55 >> (j / B - 1)) & 8'h01);
      total++;
      if (tx !== exp) begin
        bad++;
        $display("FAIL single_0x55 j=%0d got=%b exp=%b", j, tx, exp);
      end
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL single_ready j=%0d got=%b exp=%b", j, fifo_ready, m_rdy);
      end
    end
  endtask

  task automatic test_string();
    logic [7:0] s [16];
    s = '{8'h53, 8'h50, 8'h49, 8'h20, 8'h64, 8'h65, 8'h62, 8'h75,
          8'h67, 8'h20, 8'h64, 8'h61, 8'h74, 8'h61, 8'h0D, 8'h0A};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      start_uart = 1'b1;
      data = s[i];
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL string_push_tx i=%0d got=%b exp=%b", i, tx, m_tx);
      end
    end
    start_uart = 1'b0;
    for (int j = 0; j < 16 * (FRAME + 1) + 20; j++) begin
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL string_tx j=%0d got=%b exp=%b", j, tx, m_tx);
      end
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL string_ready j=%0d got=%b exp=%b", j, fifo_ready, m_rdy);
      end
    end
  endtask

  task automatic test_fill_and_full_pop();
    do_reset();
    start_uart = 1'b1;
    data = 8'h10;
    tick();
    start_uart = 1'b0;
    repeat (5) tick();   // first frame now in flight
    for (int i = 0; i < 65; i++) begin
      start_uart = 1'b1;
      data = 8'($urandom);
      tick();
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL fill_ready i=%0d got=%b exp=%b", i, fifo_ready, m_rdy);
      end
    end
    start_uart = 1'b0;
    total++;
    if (fifo_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full got=%b exp=0", fifo_ready);
    end
    for (int i = 0; i < FRAME + 10 && m_busy; i++) begin
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL fill_tx i=%0d got=%b exp=%b", i, tx, m_tx);
      end
      total++;
      if (fifo_ready !== 1'b0) begin
        bad++;
        $display("FAIL fill_stay_full i=%0d got=%b exp=0", i, fifo_ready);
      end
    end
    total++;
    if (m_busy) begin
      bad++;
      $display("FAIL fill_timeout frame did not end within budget");
    end
    // next edge pops while full; the push on that same edge must be dropped
    start_uart = 1'b1;
    data = 8'hEE;
    tick();
    start_uart = 1'b0;
    total++;
    if (fifo_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_ready got=%b exp=1", fifo_ready);
    end
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_start got=%b exp=0", tx);
    end
    for (int j = 0; j < 300; j++) begin
      start_uart = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      tick();
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL after_pop_ready j=%0d got=%b exp=%b", j, fifo_ready, m_rdy);
      end
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL after_pop_tx j=%0d got=%b exp=%b", j, tx, m_tx);
      end
    end
    start_uart = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      start_uart = 1'b1;
      data = (i == 0) ? 8'hA3 : 8'($urandom);
      tick();
    end
    start_uart = 1'b0;
    for (int j = 0; j < 4 * B; j++) begin
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL mid_tx j=%0d got=%b exp=%b", j, tx, m_tx);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_tx got=%b exp=1", tx);
    end
    total++;
    if (fifo_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_ready got=%b exp=1", fifo_ready);
    end
    rst = 1'b0;
    for (int j = 0; j < FRAME + 100; j++) begin
      tick();
      total++;
      if (tx !== 1'b1) begin
        bad++;
        $display("FAIL mid_no_frames j=%0d got=%b exp=1", j, tx);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_uart = 1'b1;
    data = 8'h41;
    tick();
    data = 8'h42;
    total++;
    if (fifo_ready !== m_rdy) begin
      bad++;
      $display("FAIL b2b_ready got=%b exp=%b", fifo_ready, m_rdy);
    end
    tick();
    start_uart = 1'b0;
    for (int j = 0; j < 2 * (FRAME + 1) + 10; j++) begin
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL b2b_tx j=%0d got=%b exp=%b", j, tx, m_tx);
      end
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL b2b_rdy j=%0d got=%b exp=%b", j, fifo_ready, m_rdy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 12000; j++) begin
      start_uart = ($urandom_range(0, 999) < 3);
      data = 8'($urandom);
      tick();
      total++;
      if (tx !== m_tx) begin
        bad++;
        $display("FAIL rand_tx j=%0d got=%b exp=%b", j, tx, m_tx);
      end
      total++;
      if (fifo_ready !== m_rdy) begin
        bad++;
        $display("FAIL rand_ready j=%0d got=%b exp=%b", j, fifo_ready, m_rdy);
      end
    end
    start_uart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_string();
    test_fill_and_full_pop();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
